gpu_blitter: RTL and testbench
==============================

Name: gpu_blitter

Overview:
Second-generation sprite blitter for the GPU. It accepts draw and clear commands into an in-order command queue and fetches sprite pixels from a sheet in memory. It writes those pixels to the framebuffer write port at one pixel per cycle through a fixed-latency read pipeline. Additions over the first-generation block: horizontal/vertical flip, colour-key transparency, framebuffer clipping with signed positions, queued clears, and parametrised widths and memory latency.

Parameters:
QUEUE_DEPTH, 8, command queue entries (power of two, >=2)
FB_WIDTH, 120, framebuffer width in pixels
FB_HEIGHT, 160, framebuffer height in pixels
FB_COORD_W, 8, width of fb_x/fb_y
COLOR_W, 16, pixel width
ADDR_W, 32, memory address width
MEM_LATENCY, 1, cycles from mem_rd/mem_addr to valid mem_rdata (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
mem_addr  out  ADDR_W  pixel read address
mem_rd  out  1  read strobe
mem_rdata  in  COLOR_W  read data, valid MEM_LATENCY cycles after mem_rd
ctrl_address  in  ADDR_W  sheet base address
ctrl_address_x  in  16  source x offset in sheet
ctrl_address_y  in  16  source y offset in sheet
ctrl_sheetsize  in  16  sheet width in pixels
ctrl_width  in  16  sprite width
ctrl_height  in  16  sprite height
ctrl_x  in  16  signed destination left
ctrl_y  in  16  signed destination top
ctrl_flags  in  3  [0] flip_x, [1] flip_y, [2] colour-key enable
ctrl_key  in  COLOR_W  transparent colour
ctrl_clear_color  in  COLOR_W  clear colour
ctrl_draw  in  1  single-cycle pulse: enqueue draw
ctrl_clear  in  1  single-cycle pulse: enqueue clear
ctrl_full  out  1  queue full
ctrl_busy  out  1  queue non-empty, or engine not IDLE, or pipeline not drained
fb_x  out  FB_COORD_W  write x
fb_y  out  FB_COORD_W  write y
fb_color  out  COLOR_W  write colour
fb_write  out  1  write strobe

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE, pipeline valid bits cleared. Asserting rstn low mid-draw aborts immediately; no further fb_write.
- Enqueue: ctrl_* are sampled in the same cycle as the pulse. ctrl_draw or ctrl_clear while ctrl_full is dropped silently. Both pulses in one cycle: clear is enqueued, draw is dropped. Commands execute strictly in order; each entry carries a type bit.
- States: IDLE -> LOAD (pop, latch entry) -> ISSUE (draw) or CLEAR -> DRAIN -> IDLE. Zero width or height goes LOAD -> IDLE with no reads or writes.
- ISSUE, one pixel per cycle, row-major with i = 0..w-1 and j = 0..h-1:
  - sx = addr_x + (flip_x ? w-1-i : i); sy = addr_y + (flip_y ? h-1-j : j).
  - mem_addr = address + sx + sy*sheetsize, computed mod 2^ADDR_W; mem_rd = 1.
  - Dest (dx, dy) = (x+i, y+j), signed 17-bit.
  - Dest coordinates and flags shift through a MEM_LATENCY-stage pipeline.
- Write: when a pipeline slot matures, fb_write is asserted on the next cycle (registered) if all hold: 0<=dx<FB_WIDTH, 0<=dy<FB_HEIGHT, and not (key enabled and mem_rdata==key). First fb_write occurs MEM_LATENCY+1 cycles after the first mem_rd. Reads are issued for clipped pixels; only the writes are suppressed.
- DRAIN: waits until the pipeline is empty, then returns to IDLE. The next command cannot be popped before the drain completes.
- CLEAR: writes every (x, y) with ctrl_clear_color latched at enqueue, row-major, x fastest, one per cycle, FB_WIDTH*FB_HEIGHT writes, no memory reads, then IDLE.
- mem_rd is 0 outside ISSUE.

Test Plan:
- 2x2 draw, address=0x100, addr_x=1, addr_y=0, sheet=4, x=3, y=5, MEM_LATENCY=1 -> reads 0x101,0x102,0x105,0x106; writes (3,5),(4,5),(3,6),(4,6) with the matching data; first fb_write 2 cycles after first mem_rd.
- Same draw with flip_x and flip_y -> read order 0x106,0x105,0x102,0x101; write order unchanged.
- Colour key 0xF81F enabled, memory returns 0xF81F for the second pixel -> 3 fb_write pulses, (4,5) skipped.
- x=-1, y=FB_HEIGHT-1, 3x2 sprite -> 6 reads; writes only at (0,159) and (1,159).
- Push 9 draws back-to-back with QUEUE_DEPTH=8 -> ctrl_full high after 8, 9th dropped, exactly 8 draws execute in order. Clear enqueued between two draws -> 19200 writes occur between them.
- MEM_LATENCY=3; rstn low mid-row -> outputs 0 asynchronously; after release, ctrl_busy=0 and the queue is empty.

Source files
------------

// File: rtl/gpu_blitter.sv
// Sprite blitter: in-order draw/clear command queue feeding a one-pixel-per-cycle
// fetch engine with flip, colour key, clipping and a fixed-latency read pipeline.
module gpu_blitter #(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned FB_WIDTH    = 120,
  parameter int unsigned FB_HEIGHT   = 160,
  parameter int unsigned FB_COORD_W  = 8,
  parameter int unsigned COLOR_W     = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd,
  input  logic [COLOR_W-1:0]    mem_rdata,
  input  logic [ADDR_W-1:0]     ctrl_address,
  input  logic [15:0]           ctrl_address_x,
  input  logic [15:0]           ctrl_address_y,
  input  logic [15:0]           ctrl_sheetsize,
  input  logic [15:0]           ctrl_width,
  input  logic [15:0]           ctrl_height,
  input  logic [15:0]           ctrl_x,
  input  logic [15:0]           ctrl_y,
  input  logic [2:0]            ctrl_flags,
  input  logic [COLOR_W-1:0]    ctrl_key,
  input  logic [COLOR_W-1:0]    ctrl_clear_color,
  input  logic                  ctrl_draw,
  input  logic                  ctrl_clear,
  output logic                  ctrl_full,
  output logic                  ctrl_busy,
  output logic [FB_COORD_W-1:0] fb_x,
  output logic [FB_COORD_W-1:0] fb_y,
  output logic [COLOR_W-1:0]    fb_color,
  output logic                  fb_write
);
  localparam int unsigned QPTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned QCNT_W = QPTR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, CLEAR} state_e;

  typedef struct packed {
    logic               is_clear;
    logic [ADDR_W-1:0]  address;
    logic [15:0]        addr_x;
    logic [15:0]        addr_y;
    logic [15:0]        sheet;
    logic [15:0]        width;
    logic [15:0]        height;
    logic [15:0]        x;
    logic [15:0]        y;
    logic [2:0]         flags;
    logic [COLOR_W-1:0] key;
    logic [COLOR_W-1:0] clear_color;
  } cmd_t;

  typedef struct packed {
    logic                  vld;
    logic                  inb;
    logic                  key_en;
    logic [FB_COORD_W-1:0] x;
    logic [FB_COORD_W-1:0] y;
  } pix_t;

  state_e                state_q, state_d;
  cmd_t                  queue_q [QUEUE_DEPTH];
  cmd_t                  cmd_q, cmd_d, new_cmd_c, head_c;
  logic [QPTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0]     count_q, count_d;
  logic                  push_c, pop_c;
  logic [15:0]           i_q, i_d, j_q, j_d;
  logic [FB_COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  pix_t                  iss_q, iss_d, mature_c;
  pix_t                  pipe_q [MEM_LATENCY];
  pix_t                  pipe_d [MEM_LATENCY];
  logic                  pipe_busy_c, pipe_busy_next_c;
  logic [15:0]           off_x_c, off_y_c;
  logic [ADDR_W-1:0]     sx_c, sy_c;
  logic [16:0]           dx_c, dy_c;
  logic                  inb_c;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  fb_write_q, fb_write_d;
  logic [FB_COORD_W-1:0] fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic [COLOR_W-1:0]    fb_color_q, fb_color_d;
  logic                  ctrl_full_q, ctrl_full_d;
  logic                  ctrl_busy_q, ctrl_busy_d;

  // Command queue bookkeeping; a full queue silently drops pulses, clear wins a tie.
  always_comb begin
    new_cmd_c.is_clear    = ctrl_clear;
    new_cmd_c.address     = ctrl_address;
    new_cmd_c.addr_x      = ctrl_address_x;
    new_cmd_c.addr_y      = ctrl_address_y;
    new_cmd_c.sheet       = ctrl_sheetsize;
    new_cmd_c.width       = ctrl_width;
    new_cmd_c.height      = ctrl_height;
    new_cmd_c.x           = ctrl_x;
    new_cmd_c.y           = ctrl_y;
    new_cmd_c.flags       = ctrl_flags;
    new_cmd_c.key         = ctrl_key;
    new_cmd_c.clear_color = ctrl_clear_color;
    push_c   = (ctrl_draw | ctrl_clear) & (count_q != QCNT_W'(QUEUE_DEPTH));
    pop_c    = (state_q == LOAD);
    head_c   = queue_q[rd_ptr_q];
    wr_ptr_d = push_c ? wr_ptr_q + QPTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + QPTR_W'(1) : rd_ptr_q;
    count_d  = count_q + QCNT_W'(push_c) - QCNT_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) queue_q[wr_ptr_q] <= new_cmd_c;
  end

  // Source address and destination of the pixel issued this cycle.
  always_comb begin
    off_x_c = cmd_q.flags[0] ? (cmd_q.width - 16'd1 - i_q) : i_q;
    off_y_c = cmd_q.flags[1] ? (cmd_q.height - 16'd1 - j_q) : j_q;
    sx_c    = ADDR_W'(cmd_q.addr_x) + ADDR_W'(off_x_c);
    sy_c    = ADDR_W'(cmd_q.addr_y) + ADDR_W'(off_y_c);
    dx_c    = {cmd_q.x[15], cmd_q.x} + {1'b0, i_q};
    dy_c    = {cmd_q.y[15], cmd_q.y} + {1'b0, j_q};
    inb_c   = ~dx_c[16] && (dx_c < 17'(FB_WIDTH)) && ~dy_c[16] && (dy_c < 17'(FB_HEIGHT));
  end

  always_comb begin
    pipe_d[0]   = iss_q;
    pipe_busy_c = iss_q.vld;
    for (int unsigned k = 1; k < MEM_LATENCY; k++) pipe_d[k] = pipe_q[k-1];
    for (int unsigned k = 0; k < MEM_LATENCY; k++) pipe_busy_c = pipe_busy_c | pipe_q[k].vld;
    mature_c = pipe_q[MEM_LATENCY-1];
  end

  // Engine next state and registered outputs.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    i_d        = i_q;
    j_d        = j_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    iss_d      = '0;
    mem_rd_d   = 1'b0;
    mem_addr_d = '0;
    fb_write_d = 1'b0;
    fb_x_d     = '0;
    fb_y_d     = '0;
    fb_color_d = '0;

    if (mature_c.vld && mature_c.inb && !(mature_c.key_en && (mem_rdata == cmd_q.key))) begin
      fb_write_d = 1'b1;
      fb_x_d     = mature_c.x;
      fb_y_d     = mature_c.y;
      fb_color_d = mem_rdata;
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = LOAD;
      end
      LOAD: begin
        cmd_d = head_c;
        i_d   = '0;
        j_d   = '0;
        cx_d  = '0;
        cy_d  = '0;
        if (head_c.is_clear)                               state_d = CLEAR;
        else if (head_c.width == '0 || head_c.height == '0) state_d = IDLE;
        else                                                state_d = ISSUE;
      end
      ISSUE: begin
        mem_rd_d     = 1'b1;
        mem_addr_d   = cmd_q.address + sx_c + sy_c * ADDR_W'(cmd_q.sheet);
        iss_d.vld    = 1'b1;
        iss_d.inb    = inb_c;
        iss_d.key_en = cmd_q.flags[2];
        iss_d.x      = dx_c[FB_COORD_W-1:0];
        iss_d.y      = dy_c[FB_COORD_W-1:0];
        if (i_q == cmd_q.width - 16'd1) begin
          i_d = '0;
          if (j_q == cmd_q.height - 16'd1) state_d = DRAIN;
          else                             j_d = j_q + 16'd1;
        end else begin
          i_d = i_q + 16'd1;
        end
      end
      DRAIN: begin
        if (!pipe_busy_c) state_d = IDLE;
      end
      CLEAR: begin
        fb_write_d = 1'b1;
        fb_x_d     = cx_q;
        fb_y_d     = cy_q;
        fb_color_d = cmd_q.clear_color;
        if (cx_q == FB_COORD_W'(FB_WIDTH - 1)) begin
          cx_d = '0;
          if (cy_q == FB_COORD_W'(FB_HEIGHT - 1)) state_d = IDLE;
          else                                    cy_d = cy_q + FB_COORD_W'(1);
        end else begin
          cx_d = cx_q + FB_COORD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_busy_next_c = iss_d.vld;
    for (int unsigned k = 0; k < MEM_LATENCY; k++) pipe_busy_next_c = pipe_busy_next_c | pipe_d[k].vld;
    ctrl_full_d = (count_d == QCNT_W'(QUEUE_DEPTH));
    ctrl_busy_d = (count_d != '0) || (state_d != IDLE) || pipe_busy_next_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      iss_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      fb_write_q  <= 1'b0;
      fb_x_q      <= '0;
      fb_y_q      <= '0;
      fb_color_q  <= '0;
      ctrl_full_q <= 1'b0;
      ctrl_busy_q <= 1'b0;
      for (int unsigned k = 0; k < MEM_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      iss_q       <= iss_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      fb_write_q  <= fb_write_d;
      fb_x_q      <= fb_x_d;
      fb_y_q      <= fb_y_d;
      fb_color_q  <= fb_color_d;
      ctrl_full_q <= ctrl_full_d;
      ctrl_busy_q <= ctrl_busy_d;
      for (int unsigned k = 0; k < MEM_LATENCY; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign fb_write  = fb_write_q;
  assign fb_x      = fb_x_q;
  assign fb_y      = fb_y_q;
  assign fb_color  = fb_color_q;
  assign ctrl_full = ctrl_full_q;
  assign ctrl_busy = ctrl_busy_q;

endmodule

// File: tb/tb_gpu_blitter.sv
// Bench for gpu_blitter: two instances (memory latency 1 and 3) share stimulus and
// are checked cycle by cycle against an expected read/write list built from the rules.
module tb_gpu_blitter;
  localparam int FB_W = 120;
  localparam int FB_H = 160;
  localparam int EMAX = 20480;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ctrl_address;
  logic [15:0] ctrl_address_x, ctrl_address_y, ctrl_sheetsize, ctrl_width, ctrl_height;
  logic [15:0] ctrl_x, ctrl_y, ctrl_key, ctrl_clear_color;
  logic [2:0]  ctrl_flags;
  logic        ctrl_draw, ctrl_clear;

  logic [1:0]  mem_rd_w, fb_write_w, ctrl_full_w, ctrl_busy_w;
  logic [31:0] mem_addr_w [2];
  logic [15:0] mem_rdata_w [2];
  logic [7:0]  fb_x_w [2];
  logic [7:0]  fb_y_w [2];
  logic [15:0] fb_color_w [2];

  logic [31:0] key_addr;
  logic [31:0] exp_rd [EMAX];
  logic [7:0]  exp_wx [EMAX];
  logic [7:0]  exp_wy [EMAX];
  logic [15:0] exp_wc [EMAX];
  int exp_rd_n, exp_wr_n;
  int rd_ptr [2];
  int wr_ptr [2];
  int first_rd [2];
  int first_wr [2];
  int cyc, checks, errors;

  // Sheet contents: a simple function of the address, with one overridable key pixel.
  function automatic logic [15:0] memf(input logic [31:0] a);
    if (a == key_addr) return 16'hF81F;
    return {a[7:0], ~a[7:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [15:0] dly [LAT];
    gpu_blitter #(.MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rstn(rstn),
      .mem_addr(mem_addr_w[g]), .mem_rd(mem_rd_w[g]), .mem_rdata(mem_rdata_w[g]),
      .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
      .ctrl_address_y(ctrl_address_y), .ctrl_sheetsize(ctrl_sheetsize),
      .ctrl_width(ctrl_width), .ctrl_height(ctrl_height), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y),
      .ctrl_flags(ctrl_flags), .ctrl_key(ctrl_key), .ctrl_clear_color(ctrl_clear_color),
      .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear),
      .ctrl_full(ctrl_full_w[g]), .ctrl_busy(ctrl_busy_w[g]),
      .fb_x(fb_x_w[g]), .fb_y(fb_y_w[g]), .fb_color(fb_color_w[g]), .fb_write(fb_write_w[g])
    );
    always @(posedge clk) begin
      dly[0] <= mem_rd_w[g] ? memf(mem_addr_w[g]) : 16'h0;
      for (int k = 1; k < int'(LAT); k++) dly[k] <= dly[k-1];
    end
    assign mem_rdata_w[g] = dly[LAT-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    exp_rd_n = 0;
    exp_wr_n = 0;
    for (int g = 0; g < 2; g++) begin
      rd_ptr[g] = 0; wr_ptr[g] = 0; first_rd[g] = -1; first_wr[g] = -1;
    end
  endtask

  task automatic model_draw(input logic [31:0] address, input int ax, input int ay,
                            input int sheet, input int w, input int h,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic [2:0] flags, input logic [15:0] key);
    int xs, ys, dx, dy, sx, sy;
    logic [31:0] a;
    logic [15:0] d;
    xs = int'($signed(x));
    ys = int'($signed(y));
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        sx = ax + (flags[0] ? w - 1 - i : i);
        sy = ay + (flags[1] ? h - 1 - j : j);
        a  = address + 32'(sx) + 32'(sy) * 32'(sheet);
        exp_rd[exp_rd_n] = a;
        exp_rd_n++;
        d  = memf(a);
        dx = xs + i;
        dy = ys + j;
        if (dx >= 0 && dx < FB_W && dy >= 0 && dy < FB_H && !(flags[2] && d == key)) begin
          exp_wx[exp_wr_n] = 8'(dx); exp_wy[exp_wr_n] = 8'(dy); exp_wc[exp_wr_n] = d;
          exp_wr_n++;
        end
      end
  endtask

  task automatic model_clear(input logic [15:0] cc);
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++) begin
        exp_wx[exp_wr_n] = 8'(x); exp_wy[exp_wr_n] = 8'(y); exp_wc[exp_wr_n] = cc;
        exp_wr_n++;
      end
  endtask

  task automatic enq(input logic clr, input logic drw, input logic [31:0] address,
                     input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] sheet,
                     input logic [15:0] w, input logic [15:0] h, input logic [15:0] x,
                     input logic [15:0] y, input logic [2:0] flags, input logic [15:0] key,
                     input logic [15:0] cc);
    ctrl_address = address; ctrl_address_x = ax; ctrl_address_y = ay;
    ctrl_sheetsize = sheet; ctrl_width = w; ctrl_height = h; ctrl_x = x; ctrl_y = y;
    ctrl_flags = flags; ctrl_key = key; ctrl_clear_color = cc;
    ctrl_draw = drw; ctrl_clear = clr;
    @(negedge clk);
    ctrl_draw = 1'b0; ctrl_clear = 1'b0;
  endtask

  task automatic finish_test(input string name, input int bound);
    int n;
    n = 0;
    while (ctrl_busy_w != 2'b00 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s_timeout: busy %b after %0d cycles, expected 00", name, ctrl_busy_w, n);
    end
    repeat (4) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_reads[%0d]", name, g), 32'(rd_ptr[g]), 32'(exp_rd_n));
      chk($sformatf("%s_writes[%0d]", name, g), 32'(wr_ptr[g]), 32'(exp_wr_n));
    end
  endtask

  initial begin
    ctrl_address = '0; ctrl_address_x = '0; ctrl_address_y = '0; ctrl_sheetsize = '0;
    ctrl_width = '0; ctrl_height = '0; ctrl_x = '0; ctrl_y = '0; ctrl_flags = '0;
    ctrl_key = '0; ctrl_clear_color = '0; ctrl_draw = 1'b0; ctrl_clear = 1'b0;
    key_addr = '1; checks = 0; errors = 0; cyc = 0;
    reset_model();

    // Compare process: every read and write is checked against the expected lists.
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rstn) begin
          for (int g = 0; g < 2; g++) begin
            if (mem_rd_w[g]) begin
              if (first_rd[g] < 0) first_rd[g] = cyc;
              checks++;
              if (rd_ptr[g] >= exp_rd_n) begin
                errors++;
                $display("FAIL rd_extra[%0d]: got addr %h, expected no read", g, mem_addr_w[g]);
              end else begin
                if (mem_addr_w[g] !== exp_rd[rd_ptr[g]]) begin
                  errors++;
                  $display("FAIL rd_addr[%0d] #%0d: got %h, expected %h", g, rd_ptr[g],
                           mem_addr_w[g], exp_rd[rd_ptr[g]]);
                end
                rd_ptr[g]++;
              end
            end
            if (fb_write_w[g]) begin
              if (first_wr[g] < 0) first_wr[g] = cyc;
              checks++;
              if (wr_ptr[g] >= exp_wr_n) begin
                errors++;
                $display("FAIL wr_extra[%0d]: got (%0d,%0d)=%h, expected no write", g,
                         fb_x_w[g], fb_y_w[g], fb_color_w[g]);
              end else begin
                if (fb_x_w[g] !== exp_wx[wr_ptr[g]] || fb_y_w[g] !== exp_wy[wr_ptr[g]] ||
                    fb_color_w[g] !== exp_wc[wr_ptr[g]]) begin
                  errors++;
                  $display("FAIL wr_pix[%0d] #%0d: got (%0d,%0d)=%h, expected (%0d,%0d)=%h", g,
                           wr_ptr[g], fb_x_w[g], fb_y_w[g], fb_color_w[g],
                           exp_wx[wr_ptr[g]], exp_wy[wr_ptr[g]], exp_wc[wr_ptr[g]]);
                end
                wr_ptr[g]++;
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_mem_rd", 32'(mem_rd_w[g]), 0);
      chk("rst_fb_write", 32'(fb_write_w[g]), 0);
      chk("rst_busy", 32'(ctrl_busy_w[g]), 0);
      chk("rst_full", 32'(ctrl_full_w[g]), 0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Basic 2x2 draw.
    reset_model();
    model_draw(32'h100, 1, 0, 4, 2, 2, 16'd3, 16'd5, 3'b000, 16'h0);
    chk("m1_rd0", exp_rd[0], 32'h101);
    chk("m1_rd1", exp_rd[1], 32'h102);
    chk("m1_rd2", exp_rd[2], 32'h105);
    chk("m1_rd3", exp_rd[3], 32'h106);
    chk("m1_wr1", {exp_wx[1], exp_wy[1], exp_wc[1]}, {8'd4, 8'd5, 16'h02FD});
    chk("m1_wr2", {exp_wx[2], exp_wy[2], exp_wc[2]}, {8'd3, 8'd6, 16'h05FA});
    enq(1'b0, 1'b1, 32'h100, 16'd1, 16'd0, 16'd4, 16'd2, 16'd2, 16'd3, 16'd5, 3'b000, 16'h0, 16'h0);
    finish_test("draw", 200);
    chk("lat1_first_wr", 32'(first_wr[0] - first_rd[0]), 32'd2);
    chk("lat3_first_wr", 32'(first_wr[1] - first_rd[1]), 32'd4);

    // Both flips: reversed read order, unchanged write order.
    reset_model();
    model_draw(32'h100, 1, 0, 4, 2, 2, 16'd3, 16'd5, 3'b011, 16'h0);
    chk("m2_rd0", exp_rd[0], 32'h106);
    chk("m2_rd3", exp_rd[3], 32'h101);
    chk("m2_wr0", {exp_wx[0], exp_wy[0], exp_wc[0]}, {8'd3, 8'd5, 16'h06F9});
    enq(1'b0, 1'b1, 32'h100, 16'd1, 16'd0, 16'd4, 16'd2, 16'd2, 16'd3, 16'd5, 3'b011, 16'h0, 16'h0);
    finish_test("flip", 200);

    // Colour key on the second pixel.
    key_addr = 32'h102;
    reset_model();
    model_draw(32'h100, 1, 0, 4, 2, 2, 16'd3, 16'd5, 3'b100, 16'hF81F);
    chk("m3_nwr", 32'(exp_wr_n), 32'd3);
    chk("m3_wr1", {exp_wx[1], exp_wy[1]}, {8'd3, 8'd6});
    enq(1'b0, 1'b1, 32'h100, 16'd1, 16'd0, 16'd4, 16'd2, 16'd2, 16'd3, 16'd5, 3'b100, 16'hF81F, 16'h0);
    finish_test("key", 200);
    key_addr = '1;

    // Clipping with a negative x and bottom-row y.
    reset_model();
    model_draw(32'h200, 0, 0, 8, 3, 2, 16'hFFFF, 16'd159, 3'b000, 16'h0);
    chk("m4_nrd", 32'(exp_rd_n), 32'd6);
    chk("m4_nwr", 32'(exp_wr_n), 32'd2);
    chk("m4_wr0", {exp_wx[0], exp_wy[0]}, {8'd0, 8'd159});
    chk("m4_wr1", {exp_wx[1], exp_wy[1]}, {8'd1, 8'd159});
    enq(1'b0, 1'b1, 32'h200, 16'd0, 16'd0, 16'd8, 16'd3, 16'd2, 16'hFFFF, 16'd159, 3'b000, 16'h0, 16'h0);
    finish_test("clip", 200);

    // Long clear holds the engine while nine draws are pushed; the ninth is dropped.
    reset_model();
    model_clear(16'h1234);
    for (int k = 0; k < 8; k++)
      model_draw(32'h300 + 32'(16 * k), 0, 0, 4, 2, 2, 16'(10 + 3 * k), 16'd20, 3'b000, 16'h0);
    enq(1'b1, 1'b0, 32'h0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 3'b000, 16'h0, 16'h1234);
    for (int k = 0; k < 9; k++) begin
      if (k == 7) chk("full_before_8th", 32'(ctrl_full_w), 32'b00);
      if (k == 8) chk("full_after_8th", 32'(ctrl_full_w), 32'b11);
      enq(1'b0, 1'b1, 32'h300 + 32'(16 * k), 16'd0, 16'd0, 16'd4, 16'd2, 16'd2,
          16'(10 + 3 * k), 16'd20, 3'b000, 16'h0, 16'h0);
    end
    finish_test("queue", 25000);

    // Draw, simultaneous clear+draw pulse (clear kept), draw.
    reset_model();
    model_draw(32'h400, 0, 0, 4, 2, 2, 16'd7, 16'd7, 3'b000, 16'h0);
    model_clear(16'hABCD);
    model_draw(32'h500, 0, 0, 4, 2, 2, 16'd9, 16'd9, 3'b000, 16'h0);
    enq(1'b0, 1'b1, 32'h400, 16'd0, 16'd0, 16'd4, 16'd2, 16'd2, 16'd7, 16'd7, 3'b000, 16'h0, 16'h0);
    enq(1'b1, 1'b1, 32'h600, 16'd0, 16'd0, 16'd4, 16'd2, 16'd2, 16'd50, 16'd50, 3'b000, 16'h0, 16'hABCD);
    enq(1'b0, 1'b1, 32'h500, 16'd0, 16'd0, 16'd4, 16'd2, 16'd2, 16'd9, 16'd9, 3'b000, 16'h0, 16'h0);
    finish_test("clear_mid", 25000);

    // Asynchronous reset in the middle of a row, with a second draw still queued.
    reset_model();
    model_draw(32'h800, 0, 0, 16, 8, 4, 16'd0, 16'd0, 3'b000, 16'h0);
    enq(1'b0, 1'b1, 32'h800, 16'd0, 16'd0, 16'd16, 16'd8, 16'd4, 16'd0, 16'd0, 3'b000, 16'h0, 16'h0);
    enq(1'b0, 1'b1, 32'h900, 16'd0, 16'd0, 16'd16, 16'd8, 16'd4, 16'd0, 16'd0, 3'b000, 16'h0, 16'h0);
    repeat (8) @(negedge clk);
    chk("pre_rst_mem_rd", 32'(mem_rd_w), 32'b11);
    #2 rstn = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("arst_mem_rd", 32'(mem_rd_w[g]), 0);
      chk("arst_mem_addr", mem_addr_w[g], 0);
      chk("arst_fb_write", 32'(fb_write_w[g]), 0);
      chk("arst_fb_color", 32'(fb_color_w[g]), 0);
      chk("arst_busy", 32'(ctrl_busy_w[g]), 0);
    end
    reset_model();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(ctrl_busy_w), 0);
    chk("post_rst_full", 32'(ctrl_full_w), 0);
    chk("post_rst_no_reads", 32'(rd_ptr[0] + rd_ptr[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
